// File: rtl/eth_mdio_master_pkg.sv
// Shared constants and types for the Clause 22 MDIO master.
// Frame layout, opcodes and FSM encoding.
package eth_mdio_master_pkg;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] ST    = 2'b01;

  localparam int B_ST   = 32;
  localparam int B_OP   = 34;
  localparam int B_PHY  = 36;
  localparam int B_REG  = 41;
  localparam int B_TA   = 46;
  localparam int B_DATA = 48;
  localparam int B_END  = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Reads carry all-ones in TA/data: the line is released there.
  function automatic logic [63:0] build_frame(
    input logic        dir,
    input logic [4:0]  aphy,
    input logic [4:0]  areg,
    input logic [15:0] txd
  );
    build_frame = {32'hFFFF_FFFF, ST,
                   dir ? OP_WR : OP_RD,
                   aphy, areg,
                   dir ? 2'b10 : 2'b11,
                   dir ? txd : 16'hFFFF};
  endfunction

endpackage

// File: rtl/eth_mdio_master_clk_div.sv
// MDC generator: tick every G_DIV clks while enabled.
// MDC low for the first half of each bit, high for the second.
module mdio_clk_div #(
  parameter int G_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall,
  output logic o_mdc
);

  localparam int W = (G_DIV > 1) ? $clog2(G_DIV) : 1;

  logic [W-1:0] r_cnt;
  logic         r_mdc;
  logic         w_tick;

  assign w_tick = i_en && (r_cnt == W'(G_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_rise = w_tick && !r_mdc;
  assign o_fall = w_tick && r_mdc;
  assign o_mdc  = r_mdc;

endmodule

// File: rtl/eth_mdio_master.sv
// Clause 22 MDIO master: one 64-bit frame per start edge.
// Drives an IOBUF-style T/O/I pad, captures read data.
module eth_mdio_master
  import eth_mdio_master_pkg::*;
#(
  parameter int G_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        usr_start,
  input  logic        usr_dir,
  input  logic [4:0]  usr_aphy,
  input  logic [4:0]  usr_areg,
  input  logic [15:0] usr_txd,
  output logic [15:0] usr_rxd,
  output logic        usr_done,
  output logic        p_out_mdio_t,
  output logic        p_out_mdio,
  input  logic        p_in_mdio,
  output logic        p_out_mdc,
  output logic [15:0] dbg_o
);

  state_t      r_state;
  logic [5:0]  r_bit;
  logic [63:0] r_sh;
  logic        r_dir;
  logic        r_mdio;
  logic        r_t;
  logic        r_done;
  logic [15:0] r_rxd;
  logic [15:0] r_rx;
  logic        r_start_d;

  logic        w_busy;
  logic        w_start;
  logic        w_rise;
  logic        w_fall;
  logic        w_mdc;
  logic [5:0]  w_nbit;
  logic [63:0] w_frame;

  assign w_busy  = (r_state == S_PRE) || (r_state == S_HDR) ||
                   (r_state == S_TA)  || (r_state == S_DATA);
  assign w_start = usr_start && !r_start_d;
  assign w_nbit  = r_bit + 6'd1;
  assign w_frame = build_frame(usr_dir, usr_aphy, usr_areg, usr_txd);

  mdio_clk_div #(.G_DIV(G_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_busy),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_mdc  (w_mdc)
  );

  // Edge detector tracks the level even through reset.
  always_ff @(posedge clk) begin
    r_start_d <= usr_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_sh    <= '0;
      r_dir   <= 1'b0;
      r_mdio  <= 1'b1;
      r_t     <= 1'b1;
      r_done  <= 1'b0;
      r_rxd   <= '0;
      r_rx    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dir   <= usr_dir;
            r_sh    <= {w_frame[62:0], 1'b0};
            r_mdio  <= w_frame[63];
            r_t     <= 1'b0;
            r_bit   <= '0;
            r_state <= S_PRE;
          end
        end
        S_PRE, S_HDR, S_TA, S_DATA: begin
          if (w_rise && (r_state == S_DATA))
            r_rx <= {r_rx[14:0], p_in_mdio};
          if (w_fall) begin
            if (r_bit == 6'(B_END - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_mdio  <= 1'b1;
              r_t     <= 1'b1;
              if (!r_dir) r_rxd <= r_rx;
            end else begin
              r_bit  <= w_nbit;
              r_mdio <= r_sh[63];
              r_sh   <= {r_sh[62:0], 1'b0};
              r_t    <= !r_dir && (w_nbit >= 6'(B_TA));
              if (w_nbit == 6'(B_ST))   r_state <= S_HDR;
              if (w_nbit == 6'(B_TA))   r_state <= S_TA;
              if (w_nbit == 6'(B_DATA)) r_state <= S_DATA;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign usr_rxd      = r_rxd;
  assign usr_done     = r_done;
  assign p_out_mdio   = r_mdio;
  assign p_out_mdio_t = r_t;
  assign p_out_mdc    = w_mdc;
  assign dbg_o = {3'b000, p_in_mdio, r_t, r_mdio,
                  w_mdc, r_bit, r_state};

endmodule

// File: tb/tb_eth_mdio_master.sv
// Directed bench for eth_mdio_master at G_DIV=2.
// Observes MDC/MDIO per bit and checks frames, timing, capture.
`timescale 1ns/100ps
module tb_eth_mdio_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        usr_start = 1'b0;
  logic        usr_dir = 1'b0;
  logic [4:0]  usr_aphy = '0;
  logic [4:0]  usr_areg = '0;
  logic [15:0] usr_txd = '0;
  logic [15:0] usr_rxd;
  logic        usr_done;
  logic        p_out_mdio_t;
  logic        p_out_mdio;
  logic        p_in_mdio = 1'b1;
  logic        p_out_mdc;
  logic [15:0] dbg_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] o_mdio, o_t;
  int          n_rise, n_done, done_k, bad_per, glitch;
  logic [15:0] rxd_at_done;
  logic        post_mdc, post_mdio, post_t, post_done;
  logic [15:0] post_rxd;

  always #2.5 clk = ~clk;

  eth_mdio_master #(.G_DIV(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .usr_start    (usr_start),
    .usr_dir      (usr_dir),
    .usr_aphy     (usr_aphy),
    .usr_areg     (usr_areg),
    .usr_txd      (usr_txd),
    .usr_rxd      (usr_rxd),
    .usr_done     (usr_done),
    .p_out_mdio_t (p_out_mdio_t),
    .p_out_mdio   (p_out_mdio),
    .p_in_mdio    (p_in_mdio),
    .p_out_mdc    (p_out_mdc),
    .dbg_o        (dbg_o)
  );

  // mode 0: plain, 1: extra start mid-frame, 2: reset at bit 40
  task automatic run_frame(input logic dir, input logic [4:0] aphy,
                           input logic [4:0] areg, input logic [15:0] txd,
                           input logic [15:0] phy, input int mode);
    int   last_rise;
    int   rst_k;
    logic pm, pmdio;
    @(negedge clk);
    usr_start = 1'b0;
    p_in_mdio = 1'b1;
    repeat (2) @(negedge clk);
    usr_dir = dir; usr_aphy = aphy; usr_areg = areg; usr_txd = txd;
    usr_start = 1'b1;
    o_mdio = '0; o_t = '0;
    n_rise = 0; n_done = 0; done_k = -1; bad_per = 0; glitch = 0;
    rxd_at_done = 'x;
    last_rise = -1; rst_k = -10;
    pm = p_out_mdc; pmdio = p_out_mdio;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 20) usr_start = 1'b0;
      if (mode == 1 && k == 100) begin
        usr_start = 1'b1;
        usr_dir = ~dir; usr_aphy = ~aphy;
        usr_areg = ~areg; usr_txd = ~txd;
      end
      if (mode == 1 && k == 120) usr_start = 1'b0;
      if (mode == 2 && k == rst_k + 1) begin
        post_mdc = p_out_mdc; post_mdio = p_out_mdio;
        post_t = p_out_mdio_t; post_done = usr_done;
        post_rxd = usr_rxd;
        rst = 1'b0;
      end
      if (p_out_mdc && !pm) begin
        if (n_rise < 64) begin
          o_mdio[63-n_rise] = p_out_mdio;
          o_t[63-n_rise] = p_out_mdio_t;
        end
        if (last_rise >= 0 && k - last_rise != 4) bad_per++;
        last_rise = k;
        n_rise++;
        if (mode == 2 && n_rise == 41) begin
          rst = 1'b1;
          rst_k = k;
        end
      end
      if (!p_out_mdc && pm) begin
        if (n_rise >= 48 && n_rise < 64) p_in_mdio = phy[63-n_rise];
        else p_in_mdio = 1'b1;
      end
      if (p_out_mdc && pm && p_out_mdio !== pmdio) glitch++;
      if (usr_done === 1'b1) begin
        n_done++;
        done_k = k;
        rxd_at_done = usr_rxd;
      end
      pm = p_out_mdc;
      pmdio = p_out_mdio;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (p_out_mdc !== 1'b0) begin failures++;
      $display("FAIL rst_mdc got=%b exp=0", p_out_mdc); end
    checks++; if (p_out_mdio !== 1'b1) begin failures++;
      $display("FAIL rst_mdio got=%b exp=1", p_out_mdio); end
    checks++; if (p_out_mdio_t !== 1'b1) begin failures++;
      $display("FAIL rst_t got=%b exp=1", p_out_mdio_t); end
    checks++; if (usr_done !== 1'b0) begin failures++;
      $display("FAIL rst_done got=%b exp=0", usr_done); end
    checks++; if (usr_rxd !== 16'h0000) begin failures++;
      $display("FAIL rst_rxd got=%h exp=0000", usr_rxd); end
    checks++; if (dbg_o !== 16'h1C00) begin failures++;
      $display("FAIL rst_dbg got=%h exp=1c00", dbg_o); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_high();
    run_frame(1'b0, 5'h00, 5'h00, 16'h0000, 16'hFFFF, 0);
    checks++; if (n_rise !== 64) begin failures++;
      $display("FAIL rdh_pulses got=%0d exp=64", n_rise); end
    checks++; if (bad_per !== 0) begin failures++;
      $display("FAIL rdh_period bad=%0d exp=0", bad_per); end
    checks++; if (o_mdio !== 64'hFFFFFFFF_6003FFFF) begin failures++;
      $display("FAIL rdh_stream got=%h exp=ffffffff6003ffff", o_mdio); end
    checks++; if (o_t !== 64'h00000000_0003FFFF) begin failures++;
      $display("FAIL rdh_t got=%h exp=000000000003ffff", o_t); end
    checks++; if (n_done !== 1 || done_k !== 257) begin failures++;
      $display("FAIL rdh_done n=%0d k=%0d exp n=1 k=257", n_done, done_k); end
    checks++; if (rxd_at_done !== 16'hFFFF) begin failures++;
      $display("FAIL rdh_rxd got=%h exp=ffff", rxd_at_done); end
    checks++; if (glitch !== 0) begin failures++;
      $display("FAIL rdh_stable got=%0d exp=0", glitch); end
  endtask

  task automatic test_write();
    run_frame(1'b1, 5'h01, 5'h1F, 16'hA5C3, 16'h0000, 0);
    checks++; if (o_mdio !== 64'hFFFFFFFF_50FEA5C3) begin failures++;
      $display("FAIL wr_stream got=%h exp=ffffffff50fea5c3", o_mdio); end
    checks++; if (o_t !== 64'h0) begin failures++;
      $display("FAIL wr_t got=%h exp=0", o_t); end
    checks++; if (n_done !== 1 || done_k !== 257) begin failures++;
      $display("FAIL wr_done n=%0d k=%0d exp n=1 k=257", n_done, done_k); end
    checks++; if (usr_rxd !== 16'hFFFF) begin failures++;
      $display("FAIL wr_rxd got=%h exp=ffff", usr_rxd); end
  endtask

  task automatic test_read_capture();
    run_frame(1'b0, 5'h03, 5'h02, 16'h0000, 16'h1234, 0);
    checks++; if (o_mdio !== 64'hFFFFFFFF_618BFFFF) begin failures++;
      $display("FAIL cap_stream got=%h exp=ffffffff618bffff", o_mdio); end
    checks++; if (rxd_at_done !== 16'h1234) begin failures++;
      $display("FAIL cap_rxd got=%h exp=1234", rxd_at_done); end
    checks++; if (usr_rxd !== 16'h1234) begin failures++;
      $display("FAIL cap_hold got=%h exp=1234", usr_rxd); end
  endtask

  task automatic test_start_busy();
    run_frame(1'b1, 5'h0A, 5'h15, 16'h0F0F, 16'h0000, 1);
    checks++; if (n_done !== 1) begin failures++;
      $display("FAIL busy_done got=%0d exp=1", n_done); end
    checks++; if (n_rise !== 64) begin failures++;
      $display("FAIL busy_pulses got=%0d exp=64", n_rise); end
    checks++; if (o_mdio !== 64'hFFFFFFFF_55560F0F) begin failures++;
      $display("FAIL busy_stream got=%h exp=ffffffff55560f0f", o_mdio); end
    checks++; if (usr_rxd !== 16'h1234) begin failures++;
      $display("FAIL busy_rxd got=%h exp=1234", usr_rxd); end
  endtask

  task automatic test_reset_mid();
    run_frame(1'b0, 5'h03, 5'h02, 16'h0000, 16'h1234, 2);
    checks++; if ({post_mdc, post_mdio, post_t} !== 3'b011) begin
      failures++;
      $display("FAIL mid_idle got=%b%b%b exp=011",
               post_mdc, post_mdio, post_t); end
    checks++; if (post_done !== 1'b0 || post_rxd !== 16'h0000) begin
      failures++;
      $display("FAIL mid_rst done=%b rxd=%h exp 0/0000",
               post_done, post_rxd); end
    checks++; if (n_done !== 0 || n_rise !== 41) begin failures++;
      $display("FAIL mid_abort done=%0d rises=%0d exp 0/41",
               n_done, n_rise); end
    run_frame(1'b0, 5'h1F, 5'h00, 16'h0000, 16'hBEEF, 0);
    checks++; if (o_mdio !== 64'hFFFFFFFF_6F83FFFF) begin failures++;
      $display("FAIL mid_next_stream got=%h exp=ffffffff6f83ffff", o_mdio); end
    checks++; if (n_done !== 1 || rxd_at_done !== 16'hBEEF) begin
      failures++;
      $display("FAIL mid_next_rxd n=%0d got=%h exp 1/beef",
               n_done, rxd_at_done); end
  endtask

  initial begin
    test_reset();
    test_read_high();
    test_write();
    test_read_capture();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
